// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe register chain.
// Mode selectors and a constant-foldable ceil(log2) for sizing the occupancy counter.
package dff_pkg;

    localparam int MODE_RIGID   = 0;
    localparam int MODE_ELASTIC = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Upstream/downstream handshake bundle for dff_pipe.
// The master side feeds words and consumes them; the slave side is the pipe.
interface dff_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    import dff_pkg::*;

    localparam int CW = clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/dff_pipe_stage.sv
// One word-wide register row with its valid bit.
// Data only captures when the incoming valid is set, so empty stages keep stale data.
module dff_pipe_stage #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] RSTVAL = '0
) (
    input  logic             C,
    input  logic             R,
    input  logic             adv,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            v <= 1'b0;
            d <= RSTVAL;
        end else if (adv) begin
            v <= vin;
            if (vin) begin
                d <= din;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage, WIDTH-bit pipeline register with per-stage valid bits.
// Elastic mode uses a combinational ready chain so bubbles collapse under backpressure.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter int               ELASTIC = MODE_ELASTIC,
    parameter logic [WIDTH-1:0] RSTVAL  = '0
) (
    input  logic       C,
    input  logic       R,
    dff_pipe_if.slave  bus
);

    localparam int CW = clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic [CW-1:0]    count_q;
    logic             in_xfer;
    logic             out_xfer;

    // A stage may move when it is empty or the stage after it moves.
    always_comb begin
        adv = '1;
        if (ELASTIC == MODE_ELASTIC) begin
            adv[DEPTH-1] = !v[DEPTH-1] | bus.out_ready;
            for (int i = DEPTH - 2; i >= 0; i--) begin
                adv[i] = !v[i] | adv[i+1];
            end
        end
    end

    assign bus.in_ready = adv[0] & !bus.flush & !R;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_xfer     = v[DEPTH-1] & ((ELASTIC == MODE_RIGID) | bus.out_ready);

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             vprev;
        logic [WIDTH-1:0] dprev;

        if (g == 0) begin : g_head
            assign vprev = in_xfer;
            assign dprev = bus.in_data;
        end else begin : g_body
            assign vprev = v[g-1] & !bus.flush;
            assign dprev = d[g-1];
        end

        // Flush forces every row to load a zero valid while leaving data untouched.
        dff_pipe_stage #(
            .WIDTH  (WIDTH),
            .RSTVAL (RSTVAL)
        ) u_stage (
            .C   (C),
            .R   (R),
            .adv (adv[g] | bus.flush),
            .vin (vprev),
            .din (dprev),
            .v   (v[g]),
            .d   (d[g])
        );
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            count_q <= '0;
        end else if (bus.flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: elastic and rigid instances side by side.
// Accepted words go into per-instance queues; monitors pop and compare on each output transfer.
module tb_dff_pipe;
    import dff_pkg::*;

    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'h5A;

    logic C = 1'b0;
    logic R = 1'b1;

    always #5 C = ~C;

    dff_pipe_if #(.WIDTH(W), .DEPTH(D)) eb ();
    dff_pipe_if #(.WIDTH(W), .DEPTH(D)) rb ();

    dff_pipe #(.WIDTH(W), .DEPTH(D), .ELASTIC(MODE_ELASTIC), .RSTVAL(RV)) dut_e (
        .C   (C),
        .R   (R),
        .bus (eb.slave)
    );

    dff_pipe #(.WIDTH(W), .DEPTH(D), .ELASTIC(MODE_RIGID), .RSTVAL(RV)) dut_r (
        .C   (C),
        .R   (R),
        .bus (rb.slave)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_acc = 0;
    logic [7:0] esb[$];
    logic [7:0] rsb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, return at the sample point 3 ns later.
    task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        @(negedge C);
        eb.in_valid  = iv;
        eb.in_data   = id;
        eb.out_ready = ordy;
        eb.flush     = fl;
        #3;
        if (iv && eb.in_ready) begin
            esb.push_back(id);
            n_acc++;
        end
    endtask

    task automatic rcyc(input logic iv, input logic [7:0] id);
        @(negedge C);
        rb.in_valid = iv;
        rb.in_data  = id;
        #3;
        if (iv && rb.in_ready) begin
            rsb.push_back(id);
        end
    endtask

    always @(negedge C) begin
        #3;
        chk("e_count_inv", 32'(eb.count), $countones(dut_e.v));
        chk("r_count_inv", 32'(rb.count), $countones(dut_r.v));
        if (R) begin
            esb.delete();
            rsb.delete();
        end else begin
            if (eb.out_valid && eb.out_ready) begin
                if (esb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL e_unexpected: got %0h expected no word at %0t", eb.out_data, $time);
                end else begin
                    chk("e_data", eb.out_data, esb.pop_front());
                end
            end
            if (rb.out_valid) begin
                if (rsb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL r_unexpected: got %0h expected no word at %0t", rb.out_data, $time);
                end else begin
                    chk("r_data", rb.out_data, rsb.pop_front());
                end
            end
            if (eb.flush) esb.delete();
            if (rb.flush) rsb.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1);
    end

    initial begin
        int acc0;
        eb.in_valid = 1'b0; eb.in_data = '0; eb.out_ready = 1'b0; eb.flush = 1'b0;
        rb.in_valid = 1'b0; rb.in_data = '0; rb.out_ready = 1'b0; rb.flush = 1'b0;

        // Power-on reset
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("rst_in_ready", eb.in_ready, 0);
        chk("rst_out_valid", eb.out_valid, 0);
        chk("rst_count", eb.count, 0);
        chk("rst_out_data", eb.out_data, RV);
        chk("rst_r_in_ready", rb.in_ready, 0);
        chk("rst_r_out_data", rb.out_data, RV);
        eb.in_valid = 1'b0;
        R = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rel_in_ready", eb.in_ready, 1);

        // T2 latency and throughput
        cyc(1'b1, 8'h11, 1'b1, 1'b0);
        chk("t2_accept", eb.in_ready, 1);
        cyc(1'b1, 8'h22, 1'b1, 1'b0);
        cyc(1'b1, 8'h33, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_lat3_valid", eb.out_valid, 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_lat4_valid", eb.out_valid, 1);
        chk("t2_lat4_count", eb.count, 3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_word2_valid", eb.out_valid, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_word3_valid", eb.out_valid, 1);
        chk("t2_word3_count", eb.count, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_drained_valid", eb.out_valid, 0);
        chk("t2_drained_count", eb.count, 0);

        // T3 backpressure: five offered, four fit
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        chk("t3_accepted", n_acc - acc0, 4);
        chk("t3_full_in_ready", eb.in_ready, 0);
        chk("t3_full_count", eb.count, 4);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t3_hold_in_ready", eb.in_ready, 0);
        chk("t3_hold_data", eb.out_data, 8'hA1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t3_drain_valid", eb.out_valid, 1);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_empty_valid", eb.out_valid, 0);
        chk("t3_empty_count", eb.count, 0);

        // T4 bubble collapse
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_count", eb.count, 2);
        chk("t4_valid_map", 32'(dut_e.v), 32'h0000_000C);
        chk("t4_head_data", eb.out_data, 8'hAA);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_a_valid", eb.out_valid, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_b_valid", eb.out_valid, 1);
        chk("t4_b_data", eb.out_data, 8'hBB);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_done_valid", eb.out_valid, 0);

        // T5 flush with simultaneous in/out
        cyc(1'b1, 8'hC1, 1'b0, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_pre_count", eb.count, 3);
        cyc(1'b1, 8'hDD, 1'b1, 1'b1);
        chk("t5_flush_in_ready", eb.in_ready, 0);
        chk("t5_flush_head", eb.out_data, 8'hC1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_post_count", eb.count, 0);
        chk("t5_post_valid", eb.out_valid, 0);

        // T1 reset mid-stream with three words held
        cyc(1'b1, 8'hE1, 1'b0, 1'b0);
        cyc(1'b1, 8'hE2, 1'b0, 1'b0);
        cyc(1'b1, 8'hE3, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_held_count", eb.count, 3);
        @(negedge C);
        #2;
        R = 1'b1;
        #1;
        chk("t1_out_valid", eb.out_valid, 0);
        chk("t1_count", eb.count, 0);
        chk("t1_out_data", eb.out_data, RV);
        chk("t1_in_ready", eb.in_ready, 0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("t1_in_ready_held", eb.in_ready, 0);
        eb.in_valid = 1'b0;
        R = 1'b0;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_release_in_ready", eb.in_ready, 1);
        chk("t1_release_valid", eb.out_valid, 0);

        // T6 rigid shift ignores out_ready
        rcyc(1'b1, 8'hA5);
        chk("t6_accept", rb.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            rcyc(1'b0, 8'h00);
            chk("t6_early_valid", rb.out_valid, 0);
            chk("t6_count", rb.count, 1);
        end
        rcyc(1'b0, 8'h00);
        chk("t6_out_valid", rb.out_valid, 1);
        chk("t6_out_data", rb.out_data, 8'hA5);
        rcyc(1'b0, 8'h00);
        chk("t6_fall_valid", rb.out_valid, 0);
        chk("t6_fall_count", rb.count, 0);

        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("e_sb_empty", esb.size(), 0);
        chk("r_sb_empty", rsb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
